// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing, code and digit-cell geometry constants
//
// Purpose: default 640x480@60 raster timing, derived totals, the special
//   digit codes understood by the seven-segment renderer, the default cell
//   geometry, and the handshake FSM state type.
// Ports: none (package).
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam logic [3:0] CODE_FAIL    = 4'd10;
  localparam logic [3:0] CODE_SUCCESS = 4'd11;
  localparam logic [3:0] CODE_BLANK   = 4'd15;

  localparam int VGA_N_DIGITS    = 4;
  localparam int VGA_DIGIT_X0    = 80;
  localparam int VGA_DIGIT_PITCH = 120;
  localparam int VGA_DIGIT_Y0    = 170;
  localparam int VGA_DIGIT_W     = 80;
  localparam int VGA_DIGIT_H     = 140;

  typedef enum logic {
    HS_IDLE,
    HS_PENDING
  } hs_state_e;

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - raster counters and raw (stage-0) sync/de generation
//
// Purpose: sx/sy pixel counters advanced by the pixel-rate enable, plus
//   combinational sync, data-enable and frame-start derived from them.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   pix_en_i           pixel-rate enable
//   sx_o, sy_o         stage-0 raster position
//   hsync_raw_o        active-low hsync for the stage-0 position
//   vsync_raw_o        active-low vsync for the stage-0 position
//   de_raw_o           active-video flag for the stage-0 position
//   frame_start_raw_o  high when the stage-0 position is (0,0)
module vga_timing import vga_pkg::*; #(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pix_en_i,
  output logic [9:0] sx_o,
  output logic [9:0] sy_o,
  output logic       hsync_raw_o,
  output logic       vsync_raw_o,
  output logic       de_raw_o,
  output logic       frame_start_raw_o
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] sx_q, sx_d;
  logic [9:0] sy_q, sy_d;

  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    if (pix_en_i) begin
      if (sx_q == H_LAST) begin
        sx_d = '0;
        sy_d = (sy_q == V_LAST) ? '0 : sy_q + 10'd1;
      end else begin
        sx_d = sx_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  end

  assign sx_o              = sx_q;
  assign sy_o              = sy_q;
  assign de_raw_o          = (sx_q < H_ACT) && (sy_q < V_ACT);
  assign hsync_raw_o       = !((sx_q >= HS_START) && (sx_q < HS_END));
  assign vsync_raw_o       = !((sy_q >= VS_START) && (sy_q < VS_END));
  assign frame_start_raw_o = (sx_q == '0) && (sy_q == '0);

endmodule

// File: rtl/digit_scan_gen.sv
// rtl/digit_scan_gen.sv - VGA scan front end mapping pixels onto digit cells
//
// Purpose: raster timing, digit-cell mapping and a two-stage alignment
//   pipeline feeding the seven-segment renderer; digit sets arrive through
//   a valid/ready handshake and are committed only at the start of vblank.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   pix_en                pixel-rate enable; all state holds when low
//   digits_in             4-bit code per cell, cell k in [4k+3:4k]
//   digits_valid/ready    handshake for digits_in
//   sx_offset, sy_offset  pixel offset inside the current cell
//   number                code shown in the current cell (15 = blank)
//   slot_active           current pixel lies inside a cell
//   hsync, vsync, de      delay-aligned raster timing (syncs active low)
//   frame_start           one-tick pulse with output pixel (0,0)
module digit_scan_gen import vga_pkg::*; #(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter int N_DIGITS    = VGA_N_DIGITS,
  parameter int DIGIT_X0    = VGA_DIGIT_X0,
  parameter int DIGIT_PITCH = VGA_DIGIT_PITCH,
  parameter int DIGIT_Y0    = VGA_DIGIT_Y0,
  parameter int DIGIT_W     = VGA_DIGIT_W,
  parameter int DIGIT_H     = VGA_DIGIT_H
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_en,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  digits_valid,
  output logic                  digits_ready,
  output logic [9:0]            sx_offset,
  output logic [9:0]            sy_offset,
  output logic [3:0]            number,
  output logic                  slot_active,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic                  frame_start
);

  localparam int         IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [10:0] Y_LO = 11'(DIGIT_Y0);
  localparam logic [10:0] Y_HI = 11'(DIGIT_Y0 + DIGIT_H);

  if (N_DIGITS > 1 && DIGIT_PITCH < DIGIT_W) begin : g_overlap_check
    $error("digit_scan_gen: DIGIT_PITCH < DIGIT_W makes digit cells overlap");
  end

  // Stage 0: raster counters
  logic [9:0] sx, sy;
  logic       hs_raw, vs_raw, de_raw, fs_raw;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .pix_en_i          (pix_en),
    .sx_o              (sx),
    .sy_o              (sy),
    .hsync_raw_o       (hs_raw),
    .vsync_raw_o       (vs_raw),
    .de_raw_o          (de_raw),
    .frame_start_raw_o (fs_raw)
  );

  // Cell mapper on the stage-0 position
  logic             col_hit_s0, row_hit_s0;
  logic [IDX_W-1:0] idx_s0;
  logic [9:0]       xoff_s0, yoff_s0;

  assign row_hit_s0 = ({1'b0, sy} >= Y_LO) && ({1'b0, sy} < Y_HI);
  assign yoff_s0    = sy - 10'(DIGIT_Y0);

  always_comb begin
    col_hit_s0 = 1'b0;
    idx_s0     = '0;
    xoff_s0    = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (({1'b0, sx} >= 11'(DIGIT_X0 + k * DIGIT_PITCH)) &&
          ({1'b0, sx} <  11'(DIGIT_X0 + k * DIGIT_PITCH + DIGIT_W))) begin
        col_hit_s0 = 1'b1;
        idx_s0     = IDX_W'(k);
        xoff_s0    = sx - 10'(DIGIT_X0 + k * DIGIT_PITCH);
      end
    end
  end

  // Handshake state; shown_q is what the raster displays
  hs_state_e                  state_q;
  logic                       ready_q;
  logic [N_DIGITS-1:0][3:0]   pending_q;
  logic [N_DIGITS-1:0][3:0]   shown_q;
  logic                       commit_tick;

  // Start of vertical blank as seen by the counters
  assign commit_tick = (sx == '0) && (sy == V_ACT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= HS_IDLE;
      ready_q   <= 1'b1;
      pending_q <= '1;
      shown_q   <= '1;
    end else if (pix_en) begin
      case (state_q)
        HS_IDLE: begin
          if (digits_valid) begin
            pending_q <= digits_in;
            state_q   <= HS_PENDING;
            ready_q   <= 1'b0;
          end
        end
        HS_PENDING: begin
          if (commit_tick) begin
            shown_q <= pending_q;
            state_q <= HS_IDLE;
            ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Stage 1 and stage 2 alignment registers
  logic             hs_s1_q, vs_s1_q, de_s1_q, fs_s1_q, hit_s1_q;
  logic [IDX_W-1:0] idx_s1_q;
  logic [9:0]       xoff_s1_q, yoff_s1_q;
  logic             hs_q, vs_q, de_q, fs_q, slot_q;
  logic [9:0]       xoff_q, yoff_q;
  logic [3:0]       number_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_s1_q   <= 1'b1;
      vs_s1_q   <= 1'b1;
      de_s1_q   <= 1'b0;
      fs_s1_q   <= 1'b0;
      hit_s1_q  <= 1'b0;
      idx_s1_q  <= '0;
      xoff_s1_q <= '0;
      yoff_s1_q <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      slot_q    <= 1'b0;
      xoff_q    <= '0;
      yoff_q    <= '0;
      number_q  <= CODE_BLANK;
    end else if (pix_en) begin
      hs_s1_q   <= hs_raw;
      vs_s1_q   <= vs_raw;
      de_s1_q   <= de_raw;
      fs_s1_q   <= fs_raw;
      hit_s1_q  <= col_hit_s0 && row_hit_s0;
      idx_s1_q  <= idx_s0;
      xoff_s1_q <= xoff_s0;
      yoff_s1_q <= yoff_s0;
      hs_q      <= hs_s1_q;
      vs_q      <= vs_s1_q;
      de_q      <= de_s1_q;
      fs_q      <= fs_s1_q;
      slot_q    <= hit_s1_q;
      xoff_q    <= hit_s1_q ? xoff_s1_q : '0;
      yoff_q    <= hit_s1_q ? yoff_s1_q : '0;
      number_q  <= hit_s1_q ? shown_q[idx_s1_q] : CODE_BLANK;
    end
  end

  assign digits_ready = ready_q;
  assign sx_offset    = xoff_q;
  assign sy_offset    = yoff_q;
  assign number       = number_q;
  assign slot_active  = slot_q;
  assign hsync        = hs_q;
  assign vsync        = vs_q;
  assign de           = de_q;
  assign frame_start  = fs_q;

endmodule

// File: tb/tb_digit_scan_gen.sv
// tb/tb_digit_scan_gen.sv - directed self-checking bench for digit_scan_gen
//
// The raster is shrunk to 50x37 (active 40x30) so whole frames stay short.
// Cells: x 2-7, 11-16, 20-25, 29-34; y 5-14. hsync low x 42-45, vsync low y 32-33.
// Commit tick: stage-0 (0,30), i.e. output pixel (49,29) is the first with the new state.
module tb_digit_scan_gen;

  localparam int HT = 50;
  localparam int VT = 37;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n, pix_en, digits_valid;
  logic [15:0] digits_in;
  logic        digits_ready, slot_active, hsync, vsync, de, frame_start;
  logic [9:0]  sx_offset, sy_offset;
  logic [3:0]  number;

  int n_checks = 0;
  int n_fail   = 0;
  int tcount   = 0;
  bit gated    = 1'b0;

  always #5 clk = ~clk;

  digit_scan_gen #(
    .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(4),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .N_DIGITS(4), .DIGIT_X0(2), .DIGIT_PITCH(9), .DIGIT_Y0(5),
    .DIGIT_W(6), .DIGIT_H(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .digits_in(digits_in), .digits_valid(digits_valid), .digits_ready(digits_ready),
    .sx_offset(sx_offset), .sy_offset(sy_offset), .number(number),
    .slot_active(slot_active), .hsync(hsync), .vsync(vsync), .de(de),
    .frame_start(frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pix(input string tag, input int num, input int xo, input int yo, input int sa);
    check({tag, ".number"}, 32'(number), num);
    check({tag, ".sx_offset"}, 32'(sx_offset), xo);
    check({tag, ".sy_offset"}, 32'(sy_offset), yo);
    check({tag, ".slot_active"}, 32'(slot_active), sa);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_pix(tag, 15, 0, 0, 0);
    check({tag, ".hsync"}, 32'(hsync), 1);
    check({tag, ".vsync"}, 32'(vsync), 1);
    check({tag, ".de"}, 32'(de), 0);
    check({tag, ".frame_start"}, 32'(frame_start), 0);
    check({tag, ".digits_ready"}, 32'(digits_ready), 1);
  endtask

  // One pix_en tick; in gated mode three idle clocks precede it.
  task automatic tick();
    if (gated) begin
      pix_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    tcount++;
  endtask

  // Advance until the output pixel is (x,y); output pixel = tick count - 2.
  task automatic goto(input int x, input int y);
    int target = y * HT + x;
    int n = 0;
    while (!(tcount >= 2 && ((tcount - 2) % FR) == target) && n < 2 * FR + 4) begin
      tick();
      n++;
    end
    if (n >= 2 * FR + 4) begin
      n_checks++;
      n_fail++;
      $error("FAIL goto_timeout: observed no pixel (%0d,%0d) expected reached", x, y);
    end
  endtask

  initial begin
    int fs_cnt, fs_at, hs_low, vs_low, de_cnt, slot_cnt;
    logic [31:0] snap;

    rst_n = 1'b0; pix_en = 1'b1; digits_valid = 1'b0; digits_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Frame 1: raster timing
    rst_n = 1'b1; tcount = 0;
    tick(); tick();
    check("first_fs", 32'(frame_start), 1);
    check("first_de", 32'(de), 1);
    fs_cnt = 0; fs_at = -1; hs_low = 0; vs_low = 0; de_cnt = 0; slot_cnt = 0;
    for (int i = 0; i < FR; i++) begin
      tick();
      if (frame_start) begin fs_cnt++; fs_at = i; end
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (de) de_cnt++;
      if (slot_active) slot_cnt++;
    end
    check("fs_count", 32'(fs_cnt), 1);
    check("fs_period", 32'(fs_at + 1), FR);
    check("hsync_low_ticks", 32'(hs_low), 4 * VT);
    check("vsync_low_ticks", 32'(vs_low), 2 * HT);
    check("de_ticks", 32'(de_cnt), 40 * 30);
    check("slot_ticks", 32'(slot_cnt), 4 * 6 * 10);

    // Frame 2: handshake mid-frame, no tearing before commit
    goto(0, 3);
    check("hs1_ready_before", 32'(digits_ready), 1);
    digits_in = 16'h4321; digits_valid = 1'b1;
    tick();
    digits_valid = 1'b0;
    check("hs1_ready_after", 32'(digits_ready), 0);
    goto(11, 5);
    check_pix("f2_old_set", 15, 0, 0, 1);
    goto(48, 29);
    check("hs1_ready_precommit", 32'(digits_ready), 0);
    tick();
    check("hs1_ready_commit", 32'(digits_ready), 1);

    // Frame 3: new set visible, cell boundaries
    goto(11, 5);  check_pix("c1_origin", 2, 0, 0, 1);
    goto(16, 14); check_pix("c1_corner", 2, 5, 9, 1);
    goto(17, 14); check_pix("gap_right", 15, 0, 0, 0);
    goto(2, 4);   check_pix("above_c0", 15, 0, 0, 0);
    goto(7, 14);  check_pix("c0_corner", 1, 5, 9, 1);
    goto(7, 15);  check_pix("below_c0", 15, 0, 0, 0);

    // Second valid while PENDING
    goto(0, 20);
    digits_in = 16'h5555; digits_valid = 1'b1;
    tick();
    check("hs2_ready_a", 32'(digits_ready), 0);
    digits_in = 16'h0987;
    goto(48, 29);
    check("hs2_hold_pending", 32'(digits_ready), 0);
    tick();
    check("hs2_commit_a", 32'(digits_ready), 1);
    tick();
    check("hs2_capture_b", 32'(digits_ready), 0);
    digits_valid = 1'b0;

    // Frame 4: set A shown, B still pending
    goto(2, 5);   check_pix("f4_c0", 5, 0, 0, 1);
    goto(20, 10); check_pix("f4_c2", 5, 0, 5, 1);
    check("f4_ready", 32'(digits_ready), 0);
    goto(49, 29);
    check("f4_commit_b", 32'(digits_ready), 1);

    // Frame 5: set B shown
    goto(2, 5);  check("f5_c0", 32'(number), 7);
    goto(11, 5); check("f5_c1", 32'(number), 8);
    goto(20, 5); check("f5_c2", 32'(number), 9);
    goto(29, 5); check("f5_c3", 32'(number), 0);

    // pix_en 1-of-4: everything holds while low, handshake ignored
    snap = {2'b0, number, sx_offset, sy_offset, slot_active, hsync, vsync, de, frame_start, digits_ready};
    digits_in = 16'hFFFF; digits_valid = 1'b1; pix_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_outputs", {2'b0, number, sx_offset, sy_offset, slot_active, hsync, vsync, de, frame_start, digits_ready}, snap);
    digits_valid = 1'b0;
    pix_en = 1'b1;
    gated = 1'b1;
    goto(34, 14); check_pix("g_c3_corner", 0, 5, 9, 1);
    goto(35, 14); check_pix("g_gap", 15, 0, 0, 0);
    goto(41, 10); check("g_hsync_41", 32'(hsync), 1);
    goto(42, 10); check("g_hsync_42", 32'(hsync), 0);
    goto(45, 10); check("g_hsync_45", 32'(hsync), 0);
    goto(46, 10); check("g_hsync_46", 32'(hsync), 1);
    goto(39, 29); check("g_de_last", 32'(de), 1);
    goto(40, 29); check("g_de_off", 32'(de), 0);
    check("g_ready_ignored", 32'(digits_ready), 1);
    gated = 1'b0;

    // Frame 6: vsync edges, then reset with a pending set
    goto(0, 31); check("vsync_31", 32'(vsync), 1);
    goto(0, 32); check("vsync_32", 32'(vsync), 0);
    goto(49, 33); check("vsync_33", 32'(vsync), 0);
    goto(0, 34); check("vsync_34", 32'(vsync), 1);
    goto(0, 15);
    digits_in = 16'h1111; digits_valid = 1'b1;
    tick();
    digits_valid = 1'b0;
    check("rst_pending_taken", 32'(digits_ready), 0);
    goto(30, 20);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midframe_reset");
    rst_n = 1'b1; tcount = 0;
    tick();
    check("restart_no_fs_yet", 32'(frame_start), 0);
    tick();
    check("restart_fs", 32'(frame_start), 1);
    goto(2, 5);  check_pix("restart_blank", 15, 0, 0, 1);
    goto(0, 31);
    goto(2, 5);  check_pix("pending_dropped", 15, 0, 0, 1);
    check("final_ready", 32'(digits_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_scan_gen.md
# digit_scan_gen

Pixel-scan front end for the digit display path. It generates 640x480@60 VGA raster timing, maps each active pixel onto one of N_DIGITS fixed digit cells, and emits per-pixel `sx_offset`, `sy_offset` and `number` for the seven-segment pixel renderer directly downstream. Syncs and data-enable are delayed to match. Digit values arrive from game logic through a valid/ready handshake and are committed only at the start of vertical blank, so a frame never tears.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48: horizontal porch and sync widths
- V_ACTIVE, 480: visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33: vertical porch and sync widths
- N_DIGITS, 4: number of digit cells
- DIGIT_X0, 80: left x of cell 0
- DIGIT_PITCH, 120: x distance between cell origins
- DIGIT_Y0, 170: top y of all cells
- DIGIT_W / DIGIT_H, 80 / 140: cell size; matches the renderer's segment box

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  **synchronous, active-low reset**
- `pix_en`  in  1  pixel-rate enable; all state advances only when high
- `digits_in`  in  4*N_DIGITS  digit codes; cell k in bits [4k+3:4k]
- `digits_valid`  in  1  `digits_in` is valid
- `digits_ready`  out  1  block can accept a new digit set
- `sx_offset`  out  10  x offset within the current cell
- `sy_offset`  out  10  y offset within the current cell
- `number`  out  4  code for the current cell: 0–9 digit, 10 FAIL, 11 SUCCESS, 15 blank
- `slot_active`  out  1  the current pixel lies inside a cell
- `hsync`  out  1  active-low horizontal sync, delay-aligned
- `vsync`  out  1  active-low vertical sync, delay-aligned
- `de`  out  1  active video, delay-aligned
- `frame_start`  out  1  one-tick pulse with the output pixel (0,0)

## Operation
- Stage 0 (counters):
  - `sx` runs 0..799 and wraps to 0.
  - `sy` increments when `sx` wraps, runs 0..524 and wraps to 0.
- Stage 1:
  - de = (sx<640 && sy<480).
  - hsync low for sx in [656,752).
  - vsync low for sy in [490,492).
  - Cell hit k when sx in [X0+k*PITCH, X0+k*PITCH+W) and sy in [Y0, Y0+H).
- Stage 2:
  - Hit: sx_offset = sx-(X0+k*PITCH), sy_offset = sy-Y0, number = shown[k], slot_active=1.
  - Miss: offsets 0, number 15, slot_active 0.
- Handshake FSM for the staged digit set:
  - IDLE: ready=1. On valid&ready, capture `digits_in` into `pending` and go to PENDING.
  - PENDING: ready=0. On the commit tick, `shown` <= `pending` and go to IDLE.
  - Commit tick: the pix_en tick where stage 0 has sx==0 && sy==V_ACTIVE.
- A capture that lands on a commit tick while in IDLE is stored and committed at the next frame.
- Codes 12–14 in `digits_in` pass through unchanged; the renderer draws nothing for them.

## Timing
- Latency is 2 pix_en ticks from stage-0 counters to every output. hsync, vsync, de, frame_start, offsets and number stay mutually aligned.
- When pix_en=0, every register holds, including the FSM and the handshake. `digits_ready` stays valid, but capture requires pix_en=1.
- Reset values:
  - sx = sy = 0
  - shown = all 15, pending = all 15, FSM in IDLE, digits_ready = 1
  - hsync = vsync = 1, de = 0, frame_start = 0
  - sx_offset = sy_offset = 0, number = 15, slot_active = 0
- Reset mid-frame restarts the raster at (0,0) and drops any pending set.
- Cells do not overlap for the defaults (x spans 80–159, 200–279, 320–399, 440–519). Overlapping parameters are illegal; checked by elaboration assertion.
- A new set is visible from the first active line of the frame after its commit tick. Worst case is about 2 frames after handshake.

## Structure
- Package `vga_pkg` holds:
  - Timing constants and derived H_TOTAL=800, V_TOTAL=525.
  - Codes CODE_FAIL=10, CODE_SUCCESS=11, CODE_BLANK=15.
  - Cell geometry defaults.
- Sub-module `vga_timing` holds the sx/sy counters with pix_en and raw sync/de generation. The top level adds the cell mapper, the alignment pipeline and the handshake FSM.

## Test plan
- Reset, then run one full frame → exactly 800*525 pix_en ticks between frame_start pulses; vsync low for 2 lines; hsync low for 96 ticks per line.
- digits_in=16'h4321, handshake mid-frame → ready drops; commit at (0,480); next frame output pixel (200,170) gives number=2, offsets (0,0); pixel (279,309) gives offsets (79,139).
- Pixel (160,170) and pixel (80,169) → slot_active=0, number=15.
- Second valid while PENDING → not accepted; accepted on the tick after commit; committed one frame later.
- pix_en toggled 1-of-4 → outputs identical per pixel to pix_en=1 run; handshake ignored when pix_en=0.
- rst_n low at (300,200) with pending set → all outputs at reset values; shown all 15; raster restarts at (0,0).
